// File: rtl/handshake_reduce_dispatch.sv
//------------------------------------------------------------------------------
// Module     : handshake_reduce_dispatch
// Description: Accepts operand pairs over a ready/valid input, reduces each pair
//              to a 2-bit result {r1,r0}, buffers results in a small FIFO and
//              hands them out in strict round-robin order over NUM_LANES
//              ready/valid output lanes.
//              Optional macro HANDSHAKE_REDUCE_DISPATCH_PERF_EN adds saturating
//              push and stall counters.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module handshake_reduce_dispatch #(
  parameter int WIDTH     = 5,
  parameter int DEPTH     = 2,
  parameter int NUM_LANES = 3
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in1,
  input  logic [WIDTH-1:0]       in2,
  output logic [NUM_LANES-1:0]   arr_valid,
  input  logic [NUM_LANES-1:0]   arr_ready,
  output logic [2*NUM_LANES-1:0] arr_data,
  output logic                   busy
`ifdef HANDSHAKE_REDUCE_DISPATCH_PERF_EN
  ,
  output logic [15:0]            perf_push_cnt,
  output logic [15:0]            perf_stall_cnt
`endif
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = $clog2(DEPTH + 1);
  localparam int c_LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [1:0]          r_mem [DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_LANE_W-1:0] r_lane_ptr;
  logic                r_in_ready;

  logic                w_push;
  logic                w_pop;
  logic [c_CNT_W-1:0]  w_count_nxt;
  logic [1:0]          w_result;
  logic                w_unused;

  // Only bit 1 of in2 participates in the reduction.
  assign w_unused = ^in2;

  assign w_result = {(&in1) & in2[1], |in1};
  assign busy     = (r_count != '0);
  assign in_ready = r_in_ready;
  assign w_push   = in_valid & r_in_ready;
  assign w_pop    = busy & arr_ready[r_lane_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_CNT_W'(1);
    end
  end

  // Pointer, occupancy and registered in_ready bookkeeping.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_lane_ptr <= '0;
      r_in_ready <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      // No pop bypass: a full FIFO deasserts in_ready even while draining.
      r_in_ready <= (w_count_nxt != c_CNT_W'(DEPTH));
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + c_PTR_W'(1);
        r_lane_ptr <= (r_lane_ptr == c_LANE_W'(NUM_LANES - 1)) ? '0
                                                             : r_lane_ptr + c_LANE_W'(1);
      end
    end
  end

  // Result storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk) begin
    if (w_push && !RESET) begin
      r_mem[r_wr_ptr] <= w_result;
    end
  end

  // Present the head entry on the selected lane only; all other lanes idle at 0.
  always_comb begin
    arr_valid = '0;
    arr_data  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (k == int'(r_lane_ptr)) begin
        arr_valid[k] = busy;
        if (busy) begin
          arr_data[2*k +: 2] = r_mem[r_rd_ptr];
        end
      end
    end
  end

`ifdef HANDSHAKE_REDUCE_DISPATCH_PERF_EN
  logic [15:0] r_perf_push;
  logic [15:0] r_perf_stall;

  // Saturating counters of accepted pairs and of stalled presentation cycles.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_perf_push  <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push && (r_perf_push != 16'hFFFF)) begin
        r_perf_push <= r_perf_push + 16'd1;
      end
      if (busy && !arr_ready[r_lane_ptr] && (r_perf_stall != 16'hFFFF)) begin
        r_perf_stall <= r_perf_stall + 16'd1;
      end
    end
  end

  assign perf_push_cnt  = r_perf_push;
  assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_handshake_reduce_dispatch.sv
//------------------------------------------------------------------------------
// Module     : tb_handshake_reduce_dispatch
// Description: Self-checking bench for handshake_reduce_dispatch using a
//              queue-based reference model of the FIFO and lane rotation.
// Revision   : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_handshake_reduce_dispatch;

  logic       clk;
  logic       RESET;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in1;
  logic [4:0] in2;
  logic [2:0] arr_valid;
  logic [2:0] arr_ready;
  logic [5:0] arr_data;
  logic       busy;
`ifdef HANDSHAKE_REDUCE_DISPATCH_PERF_EN
  logic [15:0] perf_push_cnt;
  logic [15:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int mq[$];
  int mlane = 0;
  int mpush = 0;
  int mstall = 0;

  handshake_reduce_dispatch #(.WIDTH(5), .DEPTH(2), .NUM_LANES(3)) dut (
    .clk       (clk),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .arr_valid (arr_valid),
    .arr_ready (arr_ready),
    .arr_data  (arr_data),
    .busy      (busy)
`ifdef HANDSHAKE_REDUCE_DISPATCH_PERF_EN
    ,
    .perf_push_cnt  (perf_push_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_result(input logic [4:0] a, input logic [4:0] b);
    int r0;
    int r1;
    r0 = (a != 0) ? 1 : 0;
    r1 = ((a == 5'd31) && (b[1] == 1'b1)) ? 1 : 0;
    return r1 * 2 + r0;
  endfunction

  function automatic logic [2:0] exp_valid();
    logic [2:0] v;
    v = '0;
    if (mq.size() != 0) v[mlane] = 1'b1;
    return v;
  endfunction

  function automatic logic [5:0] exp_data();
    logic [5:0] d;
    d = '0;
    if (mq.size() != 0) d = 6'(mq[0] << (2 * mlane));
    return d;
  endfunction

  // Drive one cycle of inputs (called at a negedge), advance the model across
  // the following posedge, and return at the next negedge.
  task automatic tick(input logic v, input logic [4:0] a, input logic [4:0] b,
                      input logic [2:0] rdy, input logic rst_i);
    bit push;
    bit pop;
    RESET = rst_i; in_valid = v; in1 = a; in2 = b; arr_ready = rdy;
    push = !rst_i && v && (mq.size() != 2);
    pop  = !rst_i && (mq.size() != 0) && rdy[mlane];
    @(posedge clk);
    if (rst_i) begin
      mq.delete(); mlane = 0; mpush = 0; mstall = 0;
    end else begin
      if (push) mpush++;
      if ((mq.size() != 0) && !rdy[mlane]) mstall++;
      if (pop) begin
        void'(mq.pop_front());
        mlane = (mlane + 1) % 3;
      end
      if (push) mq.push_back(ref_result(a, b));
    end
    @(negedge clk);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 3'b000, 1);
    tick(0, 0, 0, 3'b000, 1);
    checks++; if (arr_valid !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b exp 000", arr_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (arr_data !== 6'd0) begin errors++; $display("FAIL reset_data: got %h exp 0", arr_data); end
`ifdef HANDSHAKE_REDUCE_DISPATCH_PERF_EN
    checks++; if (perf_push_cnt !== 16'd0 || perf_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_perf: got %0d/%0d exp 0/0", perf_push_cnt, perf_stall_cnt); end
`endif
  endtask

  task automatic test_single();
    tick(1, 5'b11111, 5'b00010, 3'b111, 0);
    checks++; if (arr_valid !== 3'b001) begin errors++; $display("FAIL single_valid: got %b exp 001", arr_valid); end
    checks++; if (arr_data[1:0] !== 2'b11) begin errors++; $display("FAIL single_data: got %b exp 11", arr_data[1:0]); end
    tick(0, 0, 0, 3'b111, 0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b exp 0", busy); end
    // lane pointer now at 1: next entry must appear on lane 1
    tick(1, 5'b00001, 5'b0, 3'b000, 0);
    checks++; if (arr_valid !== 3'b010) begin errors++; $display("FAIL single_lane1: got %b exp 010", arr_valid); end
  endtask

  task automatic test_rotation();
    logic [4:0] ops [4];
    logic [2:0] ev  [4];
    logic [5:0] ed  [4];
    ops[0] = 5'b00001; ops[1] = 5'b00000; ops[2] = 5'b11111; ops[3] = 5'b00100;
    ev[0] = 3'b001; ev[1] = 3'b010; ev[2] = 3'b100; ev[3] = 3'b001;
    ed[0] = 6'b000001; ed[1] = 6'b000000; ed[2] = 6'b010000; ed[3] = 6'b000001;
    tick(0, 0, 0, 3'b000, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, ops[i], 5'b0, 3'b111, 0);
      checks++; if (arr_valid !== ev[i] || arr_data !== ed[i]) begin
        errors++; $display("FAIL rotation_%0d: got valid=%b data=%b exp valid=%b data=%b", i, arr_valid, arr_data, ev[i], ed[i]);
      end
      tick(0, 0, 0, 3'b111, 0);
    end
  endtask

  task automatic test_full();
    tick(0, 0, 0, 3'b000, 1);
    tick(1, 5'b00001, 0, 3'b000, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %b exp 1", in_ready); end
    tick(1, 5'b11111, 5'b00010, 3'b000, 0);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready2: got %b exp 0", in_ready); end
    tick(1, 5'b00000, 0, 3'b000, 0);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1 || arr_valid !== 3'b001) begin
      errors++; $display("FAIL full_hold: got ready=%b busy=%b valid=%b exp 0 1 001", in_ready, busy, arr_valid);
    end
    // pop while producer keeps offering: no bypass, offer not taken this cycle
    tick(1, 5'b00000, 0, 3'b001, 0);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_release: got %b exp 1", in_ready); end
    checks++; if (arr_valid !== 3'b010 || arr_data !== 6'b001100) begin
      errors++; $display("FAIL full_next: got valid=%b data=%b exp 010 001100", arr_valid, arr_data);
    end
  endtask

  task automatic test_lane_block();
    logic [5:0] held;
    tick(0, 0, 0, 3'b000, 1);
    tick(1, 5'b00001, 0, 3'b111, 0);
    tick(0, 0, 0, 3'b111, 0);
    tick(1, 5'b11111, 5'b00010, 3'b000, 0);
    tick(1, 5'b00001, 0, 3'b000, 0);
    held = arr_data;
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 3'b101, 0);
      checks++; if (arr_valid !== 3'b010 || arr_data !== 6'b001100 || held !== arr_data) begin
        errors++; $display("FAIL lane_block_%0d: got valid=%b data=%b exp 010 001100", i, arr_valid, arr_data);
      end
    end
    tick(0, 0, 0, 3'b010, 0);
    checks++; if (arr_valid !== 3'b100 || arr_data !== 6'b010000) begin
      errors++; $display("FAIL lane_unblock: got valid=%b data=%b exp 100 010000", arr_valid, arr_data);
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 5'b00001, 0, 3'b000, 0);
    tick(1, 5'b00001, 0, 3'b000, 0);
    tick(1, 5'b00001, 0, 3'b111, 1);
    checks++; if (arr_valid !== 3'b000 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid: got valid=%b busy=%b ready=%b exp 000 0 1", arr_valid, busy, in_ready);
    end
`ifdef HANDSHAKE_REDUCE_DISPATCH_PERF_EN
    checks++; if (perf_push_cnt !== 16'd0 || perf_stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_mid_perf: got %0d/%0d exp 0/0", perf_push_cnt, perf_stall_cnt); end
`endif
    tick(1, 5'b11111, 5'b00000, 3'b000, 0);
    checks++; if (arr_valid !== 3'b001 || arr_data !== 6'b000001) begin
      errors++; $display("FAIL reset_mid_lane0: got valid=%b data=%b exp 001 000001", arr_valid, arr_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 3'($urandom),
           ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
      checks++; if (arr_valid !== exp_valid() || arr_data !== exp_data() ||
                    in_ready !== (mq.size() != 2) || busy !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL random_%0d: got valid=%b data=%b ready=%b busy=%b exp valid=%b data=%b ready=%b busy=%b",
                 i, arr_valid, arr_data, in_ready, busy, exp_valid(), exp_data(), mq.size() != 2, mq.size() != 0);
      end
`ifdef HANDSHAKE_REDUCE_DISPATCH_PERF_EN
      checks++; if (perf_push_cnt !== 16'(mpush) || perf_stall_cnt !== 16'(mstall)) begin
        errors++; $display("FAIL random_perf_%0d: got %0d/%0d exp %0d/%0d", i, perf_push_cnt, perf_stall_cnt, mpush, mstall);
      end
`endif
    end
  endtask

  initial begin
    RESET = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; arr_ready = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_full();
    test_lane_block();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
